johnson_counter_n: RTL and testbench

//  Parametrised successor to the fixed 4-bit Johnson counter. Generates a WIDTH-bit

---
 rtl/johnson_pkg.sv | 84 ++++++++
 rtl/jc_phase_decode.sv | 57 +++++
 rtl/johnson_counter_n.sv | 124 ++++++++++++
 tb/tb_johnson_counter_n.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// ---------------------------------------------------------------------------
// johnson_pkg
// Shared types and pure helper functions for the Johnson / ring counter.
//
// Contents:
//   JC_MAX_W          widest counter the helpers support
//   jc_mode_t         JC_JOHNSON (twisted ring, 2*W states) / JC_RING (W states)
//   jc_word_t         JC_MAX_W-bit carrier for counter values
//   jc_reset_pattern  first state of the sequence for a given mode
//   jc_is_legal       membership test for the sequence of a given mode
//   jc_step           one forward or reverse step of a given mode
//
// Packages cannot be parameterised, so the helpers take the live counter
// width as an argument and work on a JC_MAX_W-bit word whose bits at and
// above the width are ignored on input and returned as zero.
// ---------------------------------------------------------------------------
package johnson_pkg;

  localparam int JC_MAX_W = 32;

  typedef enum logic {
    JC_JOHNSON = 1'b0,
    JC_RING    = 1'b1
  } jc_mode_t;

  typedef logic [JC_MAX_W-1:0] jc_word_t;

  // Johnson sequences start at all zeros, ring sequences at {0..0,1}.
  function automatic jc_word_t jc_reset_pattern(input jc_mode_t mode);
    jc_word_t res;
    res    = '0;
    res[0] = (mode == JC_RING);
    return res;
  endfunction

  // Johnson: the value is a single run of ones anchored at one end, i.e. at
  // most one boundary between adjacent bits. Ring: exactly one bit set.
  function automatic logic jc_is_legal(input jc_word_t value,
                                       input jc_mode_t mode,
                                       input int       width);
    int edges;
    int ones;
    edges = 0;
    ones  = 0;
    for (int i = 0; i < JC_MAX_W - 1; i++) begin
      if ((i < width - 1) && (value[i] != value[i+1])) edges++;
    end
    for (int i = 0; i < JC_MAX_W; i++) begin
      if ((i < width) && value[i]) ones++;
    end
    return (mode == JC_JOHNSON) ? (edges <= 1) : (ones == 1);
  endfunction

  // Forward shifts towards the MSB, reverse towards the LSB. The bit fed in
  // at the far end is inverted for Johnson and passed straight for ring.
  function automatic jc_word_t jc_step(input jc_word_t value,
                                       input jc_mode_t mode,
                                       input logic     dir,
                                       input int       width);
    jc_word_t fwd;
    jc_word_t rev;
    logic     msb;
    logic     lsb;
    fwd = '0;
    rev = '0;
    msb = 1'b0;
    lsb = value[0];
    for (int i = 0; i < JC_MAX_W; i++) begin
      if (i == width - 1) msb = value[i];
    end
    for (int i = 1; i < JC_MAX_W; i++) begin
      if (i < width) fwd[i] = value[i-1];
    end
    fwd[0] = (mode == JC_JOHNSON) ? ~msb : msb;
    for (int i = 0; i < JC_MAX_W - 1; i++) begin
      if (i < width - 1) rev[i] = value[i+1];
    end
    for (int i = 0; i < JC_MAX_W; i++) begin
      if (i == width - 1) rev[i] = (mode == JC_JOHNSON) ? ~lsb : lsb;
    end
    return dir ? rev : fwd;
  endfunction

endpackage

// File: rtl/jc_phase_decode.sv
// ---------------------------------------------------------------------------
// jc_phase_decode
// Purely combinational decode of a counter value into its step index.
//
// Parameters:
//   WIDTH    counter width (>= 2)
//   PHASE_W  width of the step index
// Ports:
//   i_value  in   WIDTH    counter register value
//   i_mode   in   1        sequence mode the value belongs to
//   o_phase  out  PHASE_W  step index (meaningless for an illegal value)
//
// Johnson: the rising half of the sequence has MSB=0 and its index equals the
// number of ones; the falling half has MSB=1 and is counted back from 2*W.
// Ring: index of the set bit.
// ---------------------------------------------------------------------------
module jc_phase_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PHASE_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0]   i_value,
  input  jc_mode_t           i_mode,
  output logic [PHASE_W-1:0] o_phase
);

  logic [WIDTH-1:0] w_bit_idx_valid;

  // Per-bit flags kept separate so the popcount/priority loop stays tidy.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bits
      assign w_bit_idx_valid[gi] = i_value[gi];
    end
  endgenerate

  always_comb begin
    int pc;
    int idx;
    pc  = 0;
    idx = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_bit_idx_valid[i]) begin
        pc  = pc + 1;
        idx = i;
      end
    end
    o_phase = '0;
    if (i_mode == JC_JOHNSON) begin
      o_phase = i_value[WIDTH-1] ? PHASE_W'(2 * WIDTH - pc) : PHASE_W'(pc);
    end else begin
      o_phase = PHASE_W'(idx);
    end
  end

endmodule

// File: rtl/johnson_counter_n.sv
// ---------------------------------------------------------------------------
// johnson_counter_n
// WIDTH-bit Johnson (twisted ring) or one-hot ring sequence generator with
// enable, direction, parallel load and self-correction of illegal states.
//
// Parameters:
//   WIDTH     counter width, 2 .. johnson_pkg::JC_MAX_W
//   PHASE_W   step index width, derived from WIDTH; leave at its default
// Ports:
//   clk       in   1        rising-edge clock
//   rst       in   1        synchronous active-high reset
//   en        in   1        advance one step this cycle
//   dir       in   1        0 = forward, 1 = reverse
//   mode      in   1        0 = Johnson, 1 = ring
//   load      in   1        load load_val this cycle
//   load_val  in   WIDTH    parallel load value
//   out       out  WIDTH    counter register
//   phase     out  PHASE_W  step index of out under the registered mode
//   wrap      out  1        registered pulse on a step across the sequence end
//   err       out  1        registered pulse when an illegal value is corrected
//
// Per edge, highest priority first: reset, load, mode change, correction of
// an illegal value, enabled step, hold. A loaded value is never checked on
// the edge that loads it; if illegal it is corrected on the following edge.
// ---------------------------------------------------------------------------
module johnson_counter_n
  import johnson_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PHASE_W = $clog2(2 * WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               dir,
  input  logic               mode,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   out,
  output logic [PHASE_W-1:0] phase,
  output logic               wrap,
  output logic               err
);

  logic [WIDTH-1:0]   r_out;
  jc_mode_t           r_mode;
  logic               r_wrap;
  logic               r_err;

  jc_mode_t           w_mode_in;
  jc_word_t           w_out_ext;
  logic               w_legal;
  logic [WIDTH-1:0]   w_step_val;
  logic [WIDTH-1:0]   w_rp_in;
  logic [WIDTH-1:0]   w_rp_cur;
  logic [PHASE_W-1:0] w_phase;
  logic [PHASE_W-1:0] w_last_phase;
  logic               w_wrap_hit;

  assign w_mode_in = jc_mode_t'(mode);

  // Zero-extend the register to the helper word width one bit at a time so
  // no out-of-range select of r_out is ever elaborated.
  genvar gi;
  generate
    for (gi = 0; gi < JC_MAX_W; gi++) begin : g_ext
      if (gi < WIDTH) begin : g_live
        assign w_out_ext[gi] = r_out[gi];
      end else begin : g_pad
        assign w_out_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign w_legal    = jc_is_legal(w_out_ext, r_mode, WIDTH);
  assign w_step_val = WIDTH'(jc_step(w_out_ext, r_mode, dir, WIDTH));
  assign w_rp_in    = WIDTH'(jc_reset_pattern(w_mode_in));
  assign w_rp_cur   = WIDTH'(jc_reset_pattern(r_mode));

  jc_phase_decode #(
    .WIDTH   (WIDTH),
    .PHASE_W (PHASE_W)
  ) u_phase (
    .i_value (r_out),
    .i_mode  (r_mode),
    .o_phase (w_phase)
  );

  // A step wraps when it leaves the last index going forward or index 0
  // going backward. Only consulted in the step branch, where out is legal.
  assign w_last_phase = (r_mode == JC_JOHNSON) ? PHASE_W'(2 * WIDTH - 1)
                                               : PHASE_W'(WIDTH - 1);
  assign w_wrap_hit   = dir ? (w_phase == '0) : (w_phase == w_last_phase);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_mode <= JC_JOHNSON;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      if (load) begin
        r_out <= load_val;
      end else if (w_mode_in != r_mode) begin
        r_out  <= w_rp_in;
        r_mode <= w_mode_in;
      end else if (!w_legal) begin
        r_out <= w_rp_cur;
        r_err <= 1'b1;
      end else if (en) begin
        r_out  <= w_step_val;
        r_wrap <= w_wrap_hit;
      end
    end
  end

  assign out   = r_out;
  assign phase = w_phase;
  assign wrap  = r_wrap;
  assign err   = r_err;

endmodule

// File: tb/tb_johnson_counter_n.sv
// ---------------------------------------------------------------------------
// tb_johnson_counter_n
// Self-checking bench: a directed table of cycles for the W=4 counter, a
// hand-written W=6 reset/wrap sequence, then randomised stimulus compared
// against a sequence-level model (states listed by index, not by shifting).
// ---------------------------------------------------------------------------
module tb_johnson_counter_n;

  logic       clk = 1'b0;
  logic       rst, en, dir, mode, load;
  logic [3:0] lv4;
  logic [5:0] lv6;
  logic [3:0] out4;
  logic [2:0] ph4;
  logic       wrap4, err4;
  logic [5:0] out6;
  logic [3:0] ph6;
  logic       wrap6, err6;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  johnson_counter_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(lv4), .out(out4), .phase(ph4), .wrap(wrap4), .err(err4)
  );

  johnson_counter_n #(.WIDTH(6)) dut6 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(lv6), .out(out6), .phase(ph6), .wrap(wrap6), .err(err6)
  );

  typedef struct {
    logic       r, e, d, m, l;
    logic [3:0] lv;
    logic [3:0] eo;
    int         ep;   // -1: phase not checked
    logic       ew, ee;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic r, e, d, m, l, input logic [3:0] lv,
                      input logic [3:0] eo, input int ep, input logic ew, ee);
    vec_t v;
    v = '{r, e, d, m, l, lv, eo, ep, ew, ee};
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the k-th state of each sequence written out directly.
  function automatic int pattern(input int md, input int k, input int w);
    int all1;
    all1 = (1 << w) - 1;
    if (md != 0) return 1 << k;
    if (k <= w) return (1 << k) - 1;
    return (all1 << (k - w)) & all1;
  endfunction

  function automatic int nstates(input int md, input int w);
    return (md != 0) ? w : 2 * w;
  endfunction

  function automatic int find_phase(input int val, input int md, input int w);
    for (int k = 0; k < nstates(md, w); k++)
      if (pattern(md, k, w) == val) return k;
    return -1;
  endfunction

  int m_val, m_mode, m_k, m_n;
  logic m_wrap, m_err;

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0;
    lv4 = '0; lv6 = '0;

    // Reset, full forward Johnson lap
    addv(1,0,0,0,0,4'h0, 4'b0000,0,0,0);
    addv(1,0,0,0,0,4'h0, 4'b0000,0,0,0);
    addv(0,1,0,0,0,4'h0, 4'b0001,1,0,0);
    addv(0,1,0,0,0,4'h0, 4'b0011,2,0,0);
    addv(0,1,0,0,0,4'h0, 4'b0111,3,0,0);
    addv(0,1,0,0,0,4'h0, 4'b1111,4,0,0);
    addv(0,1,0,0,0,4'h0, 4'b1110,5,0,0);
    addv(0,1,0,0,0,4'h0, 4'b1100,6,0,0);
    addv(0,1,0,0,0,4'h0, 4'b1000,7,0,0);
    addv(0,1,0,0,0,4'h0, 4'b0000,0,1,0);
    addv(0,1,0,0,0,4'h0, 4'b0001,1,0,0);
    // Forward to phase 3, then reverse across 0
    addv(0,1,0,0,0,4'h0, 4'b0011,2,0,0);
    addv(0,1,0,0,0,4'h0, 4'b0111,3,0,0);
    addv(0,1,1,0,0,4'h0, 4'b0011,2,0,0);
    addv(0,1,1,0,0,4'h0, 4'b0001,1,0,0);
    addv(0,1,1,0,0,4'h0, 4'b0000,0,0,0);
    addv(0,1,1,0,0,4'h0, 4'b1000,7,1,0);
    // To phase 5, switch to ring, lap the ring
    addv(0,1,1,0,0,4'h0, 4'b1100,6,0,0);
    addv(0,1,1,0,0,4'h0, 4'b1110,5,0,0);
    addv(0,1,0,1,0,4'h0, 4'b0001,0,0,0);
    addv(0,1,0,1,0,4'h0, 4'b0010,1,0,0);
    addv(0,1,0,1,0,4'h0, 4'b0100,2,0,0);
    addv(0,1,0,1,0,4'h0, 4'b1000,3,0,0);
    addv(0,1,0,1,0,4'h0, 4'b0001,0,1,0);
    // Ring illegal load with en held; then ring reverse wrap
    addv(0,1,0,1,1,4'b0110, 4'b0110,-1,0,0);
    addv(0,1,0,1,0,4'h0, 4'b0001,0,0,1);
    addv(0,1,0,1,0,4'h0, 4'b0010,1,0,0);
    addv(0,1,1,1,0,4'h0, 4'b0001,0,0,0);
    addv(0,1,1,1,0,4'h0, 4'b1000,3,1,0);
    // Back to Johnson, illegal load with en low
    addv(0,0,0,0,0,4'h0, 4'b0000,0,0,0);
    addv(0,0,0,0,1,4'b0101, 4'b0101,-1,0,0);
    addv(0,0,0,0,0,4'h0, 4'b0000,0,0,1);
    addv(0,0,0,0,0,4'h0, 4'b0000,0,0,0);
    // Legal load then step; reset overriding load and en
    addv(0,0,0,0,1,4'b1110, 4'b1110,5,0,0);
    addv(0,1,0,0,0,4'h0, 4'b1100,6,0,0);
    addv(1,1,0,0,1,4'b1111, 4'b0000,0,0,0);
    // Load beats a simultaneous mode change; the change lands next edge
    addv(0,1,0,1,1,4'b0100, 4'b0100,-1,0,0);
    addv(0,1,0,1,0,4'h0, 4'b0001,0,0,0);

    foreach (vq[i]) begin
      rst = vq[i].r; en = vq[i].e; dir = vq[i].d; mode = vq[i].m;
      load = vq[i].l; lv4 = vq[i].lv;
      tick();
      check($sformatf("vec%0d.out", i), 32'(out4), 32'(vq[i].eo));
      check($sformatf("vec%0d.wrap", i), 32'(wrap4), 32'(vq[i].ew));
      check($sformatf("vec%0d.err", i), 32'(err4), 32'(vq[i].ee));
      if (vq[i].ep >= 0) check($sformatf("vec%0d.phase", i), 32'(ph4), 32'(vq[i].ep));
    end

    // W=6: step mid-sequence, reset with load+en, then one full lap
    rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; lv6 = '0;
    tick();
    check("w6.rst.out", 32'(out6), 32'd0);
    rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("w6.pre%0d.phase", k), 32'(ph6), 32'(k));
    end
    rst = 1'b1; load = 1'b1; lv6 = 6'b101010;
    tick();
    check("w6.midrst.out", 32'(out6), 32'd0);
    check("w6.midrst.err", 32'(err6), 32'd0);
    check("w6.midrst.wrap", 32'(wrap6), 32'd0);
    rst = 1'b0; load = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("w6.lap%0d.wrap", k), 32'(wrap6), 32'(k == 12));
      check($sformatf("w6.lap%0d.phase", k), 32'(ph6), 32'(k % 12));
    end
    check("w6.lap.out", 32'(out6), 32'd0);

    // Randomised run of the W=4 counter against the sequence model
    rst = 1'b1; load = 1'b0; en = 1'b0; mode = 1'b0;
    tick();
    m_val = 0; m_mode = 0;
    for (int c = 0; c < 500; c++) begin
      rst  = ($urandom_range(31) == 0);
      load = ($urandom_range(7) == 0);
      lv4  = 4'($urandom);
      if ($urandom_range(15) == 0) mode = ~mode;
      en   = ($urandom_range(3) != 0);
      dir  = 1'($urandom);
      m_wrap = 1'b0; m_err = 1'b0;
      if (rst) begin
        m_val = 0; m_mode = 0;
      end else if (load) begin
        m_val = int'(lv4);
      end else if (int'(mode) != m_mode) begin
        m_mode = int'(mode); m_val = pattern(m_mode, 0, 4);
      end else if (find_phase(m_val, m_mode, 4) < 0) begin
        m_val = pattern(m_mode, 0, 4); m_err = 1'b1;
      end else if (en) begin
        m_k = find_phase(m_val, m_mode, 4);
        m_n = nstates(m_mode, 4);
        if (dir) begin
          m_wrap = (m_k == 0); m_k = (m_k + m_n - 1) % m_n;
        end else begin
          m_wrap = (m_k == m_n - 1); m_k = (m_k + 1) % m_n;
        end
        m_val = pattern(m_mode, m_k, 4);
      end
      tick();
      check($sformatf("rnd%0d.out", c), 32'(out4), 32'(m_val));
      check($sformatf("rnd%0d.wrap", c), 32'(wrap4), 32'(m_wrap));
      check($sformatf("rnd%0d.err", c), 32'(err4), 32'(m_err));
      m_k = find_phase(m_val, m_mode, 4);
      if (m_k >= 0) check($sformatf("rnd%0d.phase", c), 32'(ph4), 32'(m_k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
